vga_sync_decoder: RTL



---
 rtl/vga_sync_decoder.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder: rebuilds pixel coordinates from active-low hsync/vsync edges and tracks lock.
// Define VGA_DEC_ERRCNT_EN to build the saturating lock-loss counter driven onto errCount.
module vga_sync_decoder #(
  parameter int unsigned HACTIVE     = 640,
  parameter int unsigned HFP         = 16,
  parameter int unsigned HSYN        = 96,
  parameter int unsigned HBP         = 48,
  parameter int unsigned VACTIVE     = 480,
  parameter int unsigned VFP         = 10,
  parameter int unsigned VSYN        = 2,
  parameter int unsigned VBP         = 33,
  parameter int unsigned LOCK_FRAMES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       hsync,
  input  logic       vsync,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       active,
  output logic       locked,
  output logic [7:0] errCount
);

  localparam int unsigned CW     = 10;
  localparam int unsigned EW     = 8;
  localparam int unsigned HTOTAL = HACTIVE + HFP + HSYN + HBP;
  localparam int unsigned VTOTAL = VACTIVE + VFP + VSYN + VBP;
  localparam int unsigned HS0    = HACTIVE + HFP;
  localparam int unsigned VS0    = VACTIVE + VFP;
  localparam int unsigned GFW    = $clog2(LOCK_FRAMES + 1);

  localparam logic [CW-1:0]  HLAST_C = CW'(HTOTAL - 1);
  localparam logic [CW-1:0]  VLAST_C = CW'(VTOTAL - 1);
  localparam logic [CW-1:0]  HS0_C   = CW'(HS0);
  localparam logic [CW-1:0]  VS0_C   = CW'(VS0);
  localparam logic [CW-1:0]  HACT_C  = CW'(HACTIVE);
  localparam logic [CW-1:0]  VACT_C  = CW'(VACTIVE);
  localparam logic [GFW-1:0] LOCK_C  = GFW'(LOCK_FRAMES);

  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_LOCKED  = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic           hs_prev_q, vs_prev_q;
  logic [CW-1:0]  x_q, x_d, y_q, y_d;
  logic [CW-1:0]  xn, yn;
  logic           h_seen_q, h_seen_d, v_seen_q, v_seen_d;
  logic [GFW-1:0] gf_q, gf_d, gf_inc;
  logic           active_q, active_d;
  logic           locked_q, locked_d;
  logic           h_fall, v_fall, x_wrap;
  logic           h_err, v_err, any_err, enter_search;

  // Edge detection, free-run prediction and phase checks
  always_comb begin
    h_fall  = hs_prev_q & ~hsync;
    v_fall  = vs_prev_q & ~vsync;
    x_wrap  = (x_q == HLAST_C);
    xn      = x_wrap ? '0 : x_q + CW'(1);
    yn      = y_q;
    if (x_wrap) begin
      yn = (y_q == VLAST_C) ? '0 : y_q + CW'(1);
    end
    x_d     = h_fall ? HS0_C : xn;
    y_d     = v_fall ? VS0_C : yn;
    h_err   = h_seen_q & (h_fall ^ (xn == HS0_C));
    v_err   = v_seen_q & (v_fall ^ ((xn == '0) && (yn == VS0_C)));
    any_err = h_err | v_err;
  end

  // Lock state machine; an error beats a lock-qualifying vsync edge
  always_comb begin
    state_d = state_q;
    gf_d    = gf_q;
    gf_inc  = gf_q + GFW'(1);
    case (state_q)
      ST_SEARCH: begin
        if (v_fall && h_seen_q) begin
          state_d = ST_ACQUIRE;
          gf_d    = '0;
        end
      end
      ST_ACQUIRE: begin
        if (any_err) begin
          state_d = ST_SEARCH;
        end else if (v_fall) begin
          gf_d = gf_inc;
          if (gf_inc == LOCK_C) begin
            state_d = ST_LOCKED;
          end
        end
      end
      ST_LOCKED: begin
        if (any_err) begin
          state_d = ST_SEARCH;
        end
      end
      default: state_d = ST_SEARCH;
    endcase

    enter_search = (state_d == ST_SEARCH) && (state_q != ST_SEARCH);
    h_seen_d     = enter_search ? 1'b0 : (h_seen_q | h_fall);
    v_seen_d     = enter_search ? 1'b0 : (v_seen_q | v_fall);
    locked_d     = (state_d == ST_LOCKED);
    active_d     = locked_d && (x_d < HACT_C) && (y_d < VACT_C);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_SEARCH;
      hs_prev_q <= 1'b1;
      vs_prev_q <= 1'b1;
      x_q       <= '0;
      y_q       <= '0;
      h_seen_q  <= 1'b0;
      v_seen_q  <= 1'b0;
      gf_q      <= '0;
      active_q  <= 1'b0;
      locked_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      hs_prev_q <= hsync;
      vs_prev_q <= vsync;
      x_q       <= x_d;
      y_q       <= y_d;
      h_seen_q  <= h_seen_d;
      v_seen_q  <= v_seen_d;
      gf_q      <= gf_d;
      active_q  <= active_d;
      locked_q  <= locked_d;
    end
  end

  assign x      = x_q;
  assign y      = y_q;
  assign active = active_q;
  assign locked = locked_q;

`ifdef VGA_DEC_ERRCNT_EN
  logic          lose_lock;
  logic [EW-1:0] err_cnt_q;

  assign lose_lock = (state_q == ST_LOCKED) && any_err;

  // Saturating count of lock losses
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_cnt_q <= '0;
    end else if (lose_lock && (err_cnt_q != {EW{1'b1}})) begin
      err_cnt_q <= err_cnt_q + EW'(1);
    end
  end

  assign errCount = err_cnt_q;
`else
  assign errCount = EW'(0);
`endif

endmodule
